fast_pyramid_sequencer: RTL and testbench

FAST_PYRAMID_SEQUENCER -- requirements
Module: fast_pyramid_sequencer

---
 rtl/fast_pyramid_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fast_pyramid_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_pyramid_sequencer.sv
// Pyramid level sequencer: streams raw pixels of each level to the FAST+NMS core
// and waits for the core's keypoint rows to drain before moving to the next level.
module fast_pyramid_sequencer #(
   parameter int MAX_LEVELS  = 4,
   parameter int MAX_W       = 1024,
   parameter int MAX_H       = 768,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [2:0]              num_levels,
   input  logic [16*MAX_LEVELS-1:0] lvl_w,
   input  logic [16*MAX_LEVELS-1:0] lvl_h,
   input  logic [7:0]              s_pix_tdata,
   input  logic                    s_pix_tvalid,
   output logic                    s_pix_tready,
   output logic [63:0]             m_core_tdata,
   output logic                    m_core_tvalid,
   input  logic                    m_core_tready,
   output logic                    m_core_tlast,
   output logic                    m_core_tuser,
   input  logic                    kp_tvalid,
   input  logic                    kp_tready,
   input  logic                    kp_tlast,
   output logic [1:0]              level_idx,
   output logic                    busy,
   output logic                    done,
   output logic                    err_cfg,
   output logic                    err_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      STREAM,
      DRAIN,
      NEXT,
      DONE,
      ERR
   } state_t;

   localparam int              WD_W     = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);
   localparam logic [15:0]     MAX_W16  = 16'(MAX_W);
   localparam logic [15:0]     MAX_H16  = 16'(MAX_H);
   localparam logic [2:0]      MAX_NL   = 3'(MAX_LEVELS);

   state_t          state, state_nxt;
   logic [1:0]      level_q;
   logic [2:0]      cur_nl;
   logic [15:0]     cur_w, cur_h;
   logic [15:0]     col, row, rows_out;
   logic [WD_W-1:0] wdog;

   logic [15:0] sel_w, sel_h;
   logic        cfg_ok;
   logic        beat_acc, last_col, last_beat, first_beat;
   logic        kp_hs, kp_row;
   logic [15:0] rows_target;
   logic        drain_ok, wd_expired, last_level;

   always_comb begin
      sel_w = '0;
      sel_h = '0;
      for (int k = 0; k < MAX_LEVELS; k++) begin
         if (int'(level_q) == k) begin
            sel_w = lvl_w[16*k +: 16];
            sel_h = lvl_h[16*k +: 16];
         end
      end
   end

   assign cfg_ok = (num_levels != 3'd0) && (num_levels <= MAX_NL) &&
                   (sel_w >= 16'd3) && (sel_w <= MAX_W16) &&
                   (sel_h >= 16'd3) && (sel_h <= MAX_H16);

   assign last_col    = (col == cur_w - 16'd1);
   assign first_beat  = (col == 16'd0) && (row == 16'd0);
   assign beat_acc    = (state == STREAM) && s_pix_tvalid && m_core_tready;
   assign last_beat   = beat_acc && last_col && (row == cur_h - 16'd1);
   assign kp_hs       = kp_tvalid && kp_tready;
   assign kp_row      = kp_hs && kp_tlast && ((state == STREAM) || (state == DRAIN));
   assign rows_target = cur_h - 16'd2;
   assign last_level  = ({1'b0, level_q} == cur_nl - 3'd1);
   assign wd_expired  = (wdog >= WD_LIMIT);

   // A final keypoint row arriving in the same cycle as watchdog expiry still counts as success.
   assign drain_ok = (rows_out == rows_target) ||
                     (kp_row && (rows_out + 16'd1 == rows_target));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CHECK;
         CHECK:   state_nxt = cfg_ok ? STREAM : ERR;
         STREAM:  if (last_beat) state_nxt = DRAIN;
         DRAIN: begin
            if (drain_ok)        state_nxt = NEXT;
            else if (wd_expired) state_nxt = ERR;
         end
         NEXT:    state_nxt = last_level ? DONE : CHECK;
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Level configuration is captured once per level so the inputs may change mid-level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_q     <= '0;
         cur_nl      <= '0;
         cur_w       <= '0;
         cur_h       <= '0;
         col         <= '0;
         row         <= '0;
         rows_out    <= '0;
         wdog        <= '0;
         err_cfg     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  err_cfg     <= 1'b0;
                  err_timeout <= 1'b0;
                  level_q     <= '0;
               end
            end
            CHECK: begin
               if (cfg_ok) begin
                  cur_nl   <= num_levels;
                  cur_w    <= sel_w;
                  cur_h    <= sel_h;
                  col      <= '0;
                  row      <= '0;
                  rows_out <= '0;
               end else begin
                  err_cfg <= 1'b1;
               end
            end
            STREAM: begin
               if (beat_acc) begin
                  if (last_col) begin
                     col <= '0;
                     row <= row + 16'd1;
                  end else begin
                     col <= col + 16'd1;
                  end
               end
               if (kp_row)    rows_out <= rows_out + 16'd1;
               if (last_beat) wdog <= '0;
            end
            DRAIN: begin
               if (kp_row) rows_out <= rows_out + 16'd1;
               if (kp_hs)
                  wdog <= '0;
               else if (!wd_expired)
                  wdog <= wdog + WD_W'(1);
               if (!drain_ok && wd_expired) err_timeout <= 1'b1;
            end
            NEXT: begin
               if (!last_level) level_q <= level_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Zero-latency pass-through: the core's backpressure reaches the pixel source directly.
   always_comb begin
      s_pix_tready  = 1'b0;
      m_core_tvalid = 1'b0;
      m_core_tdata  = '0;
      m_core_tlast  = 1'b0;
      m_core_tuser  = 1'b0;
      if (state == STREAM) begin
         s_pix_tready  = m_core_tready;
         m_core_tvalid = s_pix_tvalid;
         m_core_tdata  = {24'd0, (first_beat ? {cur_w, cur_h} : 32'd0), s_pix_tdata};
         m_core_tlast  = last_col;
         m_core_tuser  = first_beat;
      end
   end

   assign level_idx = level_q;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_fast_pyramid_sequencer.sv
// Scoreboard bench for fast_pyramid_sequencer: the driver queues expected core beats,
// a negedge monitor pops and compares every accepted beat.
module tb_fast_pyramid_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  num_levels;
   logic [63:0] lvl_w, lvl_h;
   logic [7:0]  s_pix_tdata;
   logic        s_pix_tvalid;
   logic        s_pix_tready;
   logic [63:0] m_core_tdata;
   logic        m_core_tvalid;
   logic        m_core_tready;
   logic        m_core_tlast;
   logic        m_core_tuser;
   logic        kp_tvalid, kp_tready, kp_tlast;
   logic [1:0]  level_idx;
   logic        busy, done, err_cfg, err_timeout;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic        user;
      logic [1:0]  lvl;
   } beat_t;

   beat_t expQ[$];
   int compared   = 0;
   int mismatched = 0;
   int beatCount  = 0;
   int tuserCount = 0;
   int tlastCount = 0;
   int doneCount  = 0;
   bit stallOn    = 0;
   bit gapsOn     = 0;

   fast_pyramid_sequencer #(
      .MAX_LEVELS (4),
      .MAX_W      (1024),
      .MAX_H      (768),
      .TIMEOUT_CYC(100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .num_levels   (num_levels),
      .lvl_w        (lvl_w),
      .lvl_h        (lvl_h),
      .s_pix_tdata  (s_pix_tdata),
      .s_pix_tvalid (s_pix_tvalid),
      .s_pix_tready (s_pix_tready),
      .m_core_tdata (m_core_tdata),
      .m_core_tvalid(m_core_tvalid),
      .m_core_tready(m_core_tready),
      .m_core_tlast (m_core_tlast),
      .m_core_tuser (m_core_tuser),
      .kp_tvalid    (kp_tvalid),
      .kp_tready    (kp_tready),
      .kp_tlast     (kp_tlast),
      .level_idx    (level_idx),
      .busy         (busy),
      .done         (done),
      .err_cfg      (err_cfg),
      .err_timeout  (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      m_core_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_core_tready = stallOn ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   // Monitor: every accepted core beat must match the head of the expected queue.
   initial begin
      beat_t got, exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (done) doneCount++;
            if (m_core_tvalid && m_core_tready) begin
               beatCount++;
               if (m_core_tuser) tuserCount++;
               if (m_core_tlast) tlastCount++;
               got = '{data: m_core_tdata, last: m_core_tlast, user: m_core_tuser, lvl: level_idx};
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_beat", 72'(expQ.size()), 72'd1);
               end else begin
                  exp = expQ.pop_front();
                  checkOutput("beat", 72'(got), 72'(exp));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   task automatic kpPulse(input int n);
      for (int k = 0; k < n; k++) begin
         kp_tvalid = 1'b1; kp_tready = 1'b1; kp_tlast = 1'b1;
         @(posedge clk); #1;
         kp_tvalid = 1'b0; kp_tready = 1'b0; kp_tlast = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic sendPixel(input logic [7:0] pix);
      bit got = 0;
      s_pix_tvalid = 1'b1;
      s_pix_tdata  = pix;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (s_pix_tready) begin
            got = 1;
            break;
         end
      end
      if (!got) checkOutput("pixel_handshake", 72'(s_pix_tready), 72'd1);
      @(posedge clk); #1;
      s_pix_tvalid = 1'b0;
   endtask

   task automatic applyStimulus(input int w, input int h, input int base, input int nPix,
                                input int kpEarly, input int kpLate, input logic [1:0] lvl);
      beat_t e;
      logic [7:0] pix;
      for (int i = 0; i < nPix; i++) begin
         if (i == w*h - 4) kpPulse(kpEarly);
         if (gapsOn && ($urandom_range(0, 3) == 0)) begin
            @(posedge clk); #1;
         end
         pix    = 8'(base + i);
         e.user = (i == 0);
         e.last = ((i % w) == w - 1);
         e.lvl  = lvl;
         e.data = {24'd0, (i == 0) ? {16'(w), 16'(h)} : 32'd0, pix};
         expQ.push_back(e);
         sendPixel(pix);
      end
      if (nPix == w*h) kpPulse(kpLate);
   endtask

   task automatic startJob(input logic [2:0] nl, input logic [63:0] w, input logic [63:0] h);
      num_levels = nl;
      lvl_w      = w;
      lvl_h      = h;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      for (int n = 0; n < budget; n++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      checkOutput("idle_reached", 72'(busy), 72'd0);
   endtask

   initial begin
      int d0, t0, l0, b0, n;
      rst_n = 1'b0; start = 1'b0; num_levels = 3'd0; lvl_w = '0; lvl_h = '0;
      s_pix_tdata = 8'h00; s_pix_tvalid = 1'b1;
      kp_tvalid = 1'b0; kp_tready = 1'b0; kp_tlast = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy",      72'(busy),          72'd0);
      checkOutput("rst_done",      72'(done),          72'd0);
      checkOutput("rst_err",       72'({err_cfg, err_timeout}), 72'd0);
      checkOutput("rst_level",     72'(level_idx),     72'd0);
      checkOutput("rst_tready",    72'(s_pix_tready),  72'd0);
      checkOutput("rst_tvalid",    72'(m_core_tvalid), 72'd0);
      checkOutput("rst_tdata",     72'({m_core_tdata, m_core_tlast, m_core_tuser}), 72'd0);
      s_pix_tvalid = 1'b0;
      rst_n = 1'b1;

      // Single level 8x4; one keypoint row during STREAM, one in DRAIN
      d0 = doneCount; t0 = tuserCount; l0 = tlastCount;
      startJob(3'd1, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0004);
      checkOutput("a_busy", 72'(busy), 72'd1);
      applyStimulus(8, 4, 8'h10, 32, 1, 1, 2'd0);
      waitIdle(20);
      checkOutput("a_done",  72'(doneCount - d0),  72'd1);
      checkOutput("a_tuser", 72'(tuserCount - t0), 72'd1);
      checkOutput("a_tlast", 72'(tlastCount - l0), 72'd4);
      checkOutput("a_err",   72'({err_cfg, err_timeout}), 72'd0);
      checkOutput("a_queue", 72'(expQ.size()), 72'd0);

      // Two levels 16x8 then 8x4
      d0 = doneCount; t0 = tuserCount;
      startJob(3'd2, 64'h0000_0000_0008_0010, 64'h0000_0000_0004_0008);
      applyStimulus(16, 8, 8'h40, 128, 0, 6, 2'd0);
      checkOutput("b_no_early_done", 72'(doneCount - d0), 72'd0);
      applyStimulus(8, 4, 8'hC0, 32, 0, 1, 2'd1);
      checkOutput("b_no_done_before_last_kp", 72'(doneCount - d0), 72'd0);
      kpPulse(1);
      waitIdle(20);
      checkOutput("b_done",  72'(doneCount - d0),  72'd1);
      checkOutput("b_tuser", 72'(tuserCount - t0), 72'd2);

      // Configuration errors: zero levels, then width 2
      for (int c = 0; c < 2; c++) begin
         d0 = doneCount; b0 = beatCount;
         s_pix_tvalid = 1'b1;
         if (c == 0) startJob(3'd0, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0004);
         else        startJob(3'd1, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0004);
         n = 0;
         while (busy && n < 3) begin
            @(posedge clk); #1;
            n++;
         end
         s_pix_tvalid = 1'b0;
         checkOutput("c_busy_low", 72'(busy), 72'd0);
         checkOutput("c_err_cfg",  72'(err_cfg), 72'd1);
         checkOutput("c_no_beats", 72'(beatCount - b0), 72'd0);
         checkOutput("c_no_done",  72'(doneCount - d0), 72'd0);
      end

      // Random core stalls and source gaps on 16x8
      stallOn = 1; gapsOn = 1;
      d0 = doneCount; l0 = tlastCount;
      startJob(3'd1, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0008);
      checkOutput("d_err_cleared", 72'(err_cfg), 72'd0);
      applyStimulus(16, 8, 8'h77, 128, 0, 6, 2'd0);
      waitIdle(20);
      stallOn = 0; gapsOn = 0;
      checkOutput("d_tlast", 72'(tlastCount - l0), 72'd8);
      checkOutput("d_done",  72'(doneCount - d0),  72'd1);
      checkOutput("d_queue", 72'(expQ.size()), 72'd0);

      // Drain watchdog: only one keypoint row for an 8x4 level
      d0 = doneCount;
      startJob(3'd1, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0004);
      applyStimulus(8, 4, 8'h20, 32, 1, 0, 2'd0);
      n = 0;
      while (!err_timeout && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("e_err_timeout", 72'(err_timeout), 72'd1);
      checkOutput("e_delay_ok", 72'((n >= 99) && (n <= 102)), 72'd1);
      waitIdle(5);
      checkOutput("e_no_done", 72'(doneCount - d0), 72'd0);

      // Reset in the middle of a row of level 1, then a fresh 8x4 job
      startJob(3'd2, 64'h0000_0000_0008_0008, 64'h0000_0000_0004_0004);
      applyStimulus(8, 4, 8'h00, 32, 0, 2, 2'd0);
      applyStimulus(8, 4, 8'h80, 11, 0, 0, 2'd1);
      s_pix_tvalid = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("f_rst_state", 72'({busy, done, err_cfg, err_timeout, level_idx}), 72'd0);
      checkOutput("f_rst_axis",  72'({s_pix_tready, m_core_tvalid, m_core_tlast, m_core_tuser}), 72'd0);
      checkOutput("f_rst_tdata", 72'(m_core_tdata), 72'd0);
      s_pix_tvalid = 1'b0;
      rst_n = 1'b1;
      d0 = doneCount;
      startJob(3'd1, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0004);
      applyStimulus(8, 4, 8'h55, 32, 2, 0, 2'd0);
      waitIdle(20);
      checkOutput("f_done",  72'(doneCount - d0), 72'd1);
      checkOutput("f_queue", 72'(expQ.size()), 72'd0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
